// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external ALU: grants one op, runs it, holds the result until consumed.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win contention instead of round-robin.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req0_op,
  input  logic [4:0]       req1_op,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00110;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic             grant_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       op_ctrl;
  logic             pick1;
  logic             accept;
  logic             rsp_done;

  function automatic logic op_legal(input logic [4:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign pick1 = req1_valid && !req0_valid;
`else
  logic rr_ptr;

  // Pointer hands priority to the requester that was not just served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (rsp_done) begin
      rr_ptr <= !grant_id;
    end
  end

  assign pick1 = req1_valid && (!req0_valid || rr_ptr);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Ready is gated by reset so nothing looks accepted while reset is held.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = '0;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (!reset && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = !pick1;
          req1_ready = pick1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        alu_a      = op_a;
        alu_b      = op_b;
        alu_ctrl   = op_ctrl;
        state_next = RESP;
      end
      RESP: begin
        rsp0_valid = !grant_id;
        rsp1_valid = grant_id;
        rsp_done   = grant_id ? rsp1_ready : rsp0_ready;
        if (rsp_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are latched at grant so the requester may drop valid afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id   <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        grant_id <= pick1;
        op_a     <= pick1 ? req1_a : req0_a;
        op_b     <= pick1 ? req1_b : req0_b;
        op_ctrl  <= pick1 ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        if (op_legal(op_ctrl)) begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_err    <= 1'b0;
        end else begin
          rsp_result <= '0;
          rsp_zero   <= 1'b0;
          rsp_err    <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (winner choice, expected result) and a behavioural external ALU.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]   req0_op, req1_op;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_err;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [4:0]   alu_ctrl;
  logic         alu_zero, busy;

  int checks = 0;
  int errors = 0;
  int favour = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // External ALU; illegal codes produce junk so the arbiter's override is visible.
  always_comb begin
    alu_result = alu_a ^ alu_b ^ 32'hDEAD_BEEF;
    alu_zero   = 1'b1;
    case (alu_ctrl)
      5'b00000: alu_result = alu_a & alu_b;
      5'b00001: alu_result = alu_a | alu_b;
      5'b00010: alu_result = alu_a + alu_b;
      5'b00110: alu_result = alu_a - alu_b;
      default: ;
    endcase
    if (alu_ctrl == 5'b00000 || alu_ctrl == 5'b00001 || alu_ctrl == 5'b00010 || alu_ctrl == 5'b00110)
      alu_zero = (alu_result == '0);
  end

  function automatic void ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op,
                                  output logic [W-1:0] r, output logic z, output logic e);
    e = 1'b0;
    case (op)
      5'b00000: r = a & b;
      5'b00001: r = a | b;
      5'b00010: r = a + b;
      5'b00110: r = a - b;
      default: begin r = '0; e = 1'b1; end
    endcase
    z = !e && (r == '0);
  endfunction

  function automatic int ref_winner(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return favour;
`endif
    end
    return v0 ? 0 : (v1 ? 1 : -1);
  endfunction

  function automatic logic [4:0] random_op();
    case ($urandom_range(0, 4))
      0: return 5'b00000;
      1: return 5'b00001;
      2: return 5'b00010;
      3: return 5'b00110;
      default: return 5'($urandom_range(7, 31));
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int n, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [4:0] op);
    if (n == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic idle_inputs();
    drive_req(0, 1'b0, '0, '0, 5'b0);
    drive_req(1, 1'b0, '0, '0, 5'b0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    favour = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    drive_req(0, 1'b1, 32'h1, 32'h2, 5'b00010);
    drive_req(1, 1'b1, 32'h3, 32'h4, 5'b00001);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    tick();
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_zero, rsp_err} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_zero, rsp_err});
    end
    checks++;
    if ({rsp_result, alu_a, alu_b, alu_ctrl} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got result=%0h alu_a=%0h alu_b=%0h ctrl=%0h expected all 0",
               rsp_result, alu_a, alu_b, alu_ctrl);
    end
    idle_inputs();
    tick();
    reset = 1'b0;
    favour = 0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    drive_req(0, 1'b1, 32'd5, 32'd3, 5'b00010);
    #1;
    checks++;
    if ({req0_ready, req1_ready, busy} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL basic_accept: got %b expected 100", {req0_ready, req1_ready, busy});
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if ({alu_a, alu_b, alu_ctrl, busy, rsp0_valid} !== {32'd5, 32'd3, 5'b00010, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL basic_exec: got a=%0h b=%0h ctrl=%0h busy=%b rsp0_valid=%b expected 5 3 2 1 0",
               alu_a, alu_b, alu_ctrl, busy, rsp0_valid);
    end
    tick();
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err} !== {2'b10, 32'd8, 2'b00}) begin
      errors++;
      $display("[TB] FAIL basic_resp: got v=%b%b result=%0h z=%b e=%b expected v=10 result=8 z=0 e=0",
               rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err);
    end
    checks++;
    if ({alu_a, alu_b, alu_ctrl} !== '0) begin
      errors++;
      $display("[TB] FAIL basic_alu_idle: got a=%0h b=%0h ctrl=%0h expected 0", alu_a, alu_b, alu_ctrl);
    end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    favour = 1;
    checks++;
    if ({busy, rsp0_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL basic_done: got busy/valid=%b expected 00", {busy, rsp0_valid});
    end
  endtask

  // Both requesters held valid from reset: service order and one op every three cycles.
  task automatic test_back_to_back();
    logic [W-1:0] er;
    logic         ez, ee;
    int           w;
    pulse_reset();
    drive_req(0, 1'b1, 32'd7, 32'd7, 5'b00110);
    drive_req(1, 1'b1, 32'hF0, 32'h0F, 5'b00001);
    for (int i = 0; i < 3; i++) begin
      w = ref_winner(1'b1, 1'b1);
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== ((w == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("[TB] FAIL b2b_grant[%0d]: got %b expected winner %0d", i, {req0_ready, req1_ready}, w);
      end
      tick();
      tick();
      if (w == 0) ref_alu(32'd7, 32'd7, 5'b00110, er, ez, ee);
      else ref_alu(32'hF0, 32'h0F, 5'b00001, er, ez, ee);
      checks++;
      if ({rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err} !== {((w == 0) ? 2'b10 : 2'b01), er, ez, ee}) begin
        errors++;
        $display("[TB] FAIL b2b_resp[%0d]: got v=%b%b result=%0h z=%b e=%b expected winner %0d result=%0h z=%b",
                 i, rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err, w, er, ez);
      end
      if (w == 0) rsp0_ready = 1'b1;
      else rsp1_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      favour = 1 - w;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_illegal();
    drive_req(1, 1'b1, 32'h1234, 32'h1234, 5'b00111);
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL illegal_accept: got %b expected 01", {req0_ready, req1_ready});
    end
    tick();
    req1_valid = 1'b0;
    tick();
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err} !== {2'b01, 32'd0, 2'b01}) begin
      errors++;
      $display("[TB] FAIL illegal_resp: got v=%b%b result=%0h z=%b e=%b expected v=01 result=0 z=0 e=1",
               rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err);
    end
    rsp0_ready = 1'b1;
    tick();
    checks++;
    if ({rsp1_valid, busy} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL illegal_wrong_ready: got valid/busy=%b expected 11", {rsp1_valid, busy});
    end
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    favour = 0;
    checks++;
    if ({busy, rsp1_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL illegal_done: got busy/valid=%b expected 00", {busy, rsp1_valid});
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] a, b, er;
    logic         ez, ee;
    a = $urandom;
    b = $urandom;
    ref_alu(a, b, 5'b00010, er, ez, ee);
    drive_req(0, 1'b1, a, b, 5'b00010);
    tick();
    drive_req(0, 1'b0, '0, '0, 5'b0);
    drive_req(1, 1'b1, 32'h55, 32'hAA, 5'b00001);
    tick();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({rsp0_valid, rsp1_valid, req1_ready, busy, rsp_result, rsp_zero, rsp_err} !== {4'b1001, er, ez, ee}) begin
        errors++;
        $display("[TB] FAIL stall[%0d]: got v=%b%b req1_ready=%b busy=%b result=%0h expected 1 0 0 1 %0h",
                 c, rsp0_valid, rsp1_valid, req1_ready, busy, rsp_result, er);
      end
      if (c < 5) tick();
    end
    rsp0_ready = 1'b1;
    req1_valid = 1'b0;
    tick();
    rsp0_ready = 1'b0;
    favour = 1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_done: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_exec();
    drive_req(0, 1'b1, 32'd9, 32'd4, 5'b00110);
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_zero, rsp_err, rsp_result, alu_a, alu_b, alu_ctrl} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_exec_outputs: got busy=%b ready=%b%b result=%0h alu_a=%0h ctrl=%0h expected all 0",
               busy, req0_ready, req1_ready, rsp_result, alu_a, alu_ctrl);
    end
    req0_valid = 1'b0;
    tick();
    reset = 1'b0;
    favour = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL reset_exec_no_rsp[%0d]: got %b expected 000", c, {rsp0_valid, rsp1_valid, busy});
      end
    end
    drive_req(0, 1'b1, 32'd20, 32'd22, 5'b00010);
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_exec_reaccept: got %b expected 1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    tick();
    checks++;
    if ({rsp0_valid, rsp_result} !== {1'b1, 32'd42}) begin
      errors++;
      $display("[TB] FAIL reset_exec_new_op: got v=%b result=%0h expected 1 2a", rsp0_valid, rsp_result);
    end
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    favour = 1;
  endtask

  task automatic test_random();
    logic [W-1:0] a [2];
    logic [W-1:0] b [2];
    logic [4:0]   op [2];
    logic         v [2];
    logic [W-1:0] er;
    logic         ez, ee;
    logic [1:0]   exp_v;
    int           w, stall;
    for (int it = 0; it < 60; it++) begin
      for (int n = 0; n < 2; n++) begin
        v[n]  = 1'($urandom_range(0, 1));
        a[n]  = $urandom;
        b[n]  = ($urandom_range(0, 3) == 0) ? a[n] : $urandom;
        op[n] = random_op();
        drive_req(n, v[n], a[n], b[n], op[n]);
      end
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      w = ref_winner(v[0], v[1]);
      exp_v = (w == 0) ? 2'b10 : ((w == 1) ? 2'b01 : 2'b00);
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== exp_v) begin
        errors++;
        $display("[TB] FAIL rand_grant[%0d]: got %b expected %b", it, {req0_ready, req1_ready}, exp_v);
      end
      if (w < 0) begin
        tick();
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rand_idle[%0d]: got busy=%b expected 0", it, busy);
        end
        continue;
      end
      tick();
      for (int n = 0; n < 2; n++) drive_req(n, 1'($urandom_range(0, 1)), $urandom, $urandom, random_op());
      #1;
      checks++;
      if ({alu_a, alu_b, alu_ctrl, req0_ready, req1_ready, busy} !== {a[w], b[w], op[w], 3'b001}) begin
        errors++;
        $display("[TB] FAIL rand_exec[%0d]: got a=%0h b=%0h ctrl=%0h rdy=%b%b expected a=%0h b=%0h ctrl=%0h rdy=00",
                 it, alu_a, alu_b, alu_ctrl, req0_ready, req1_ready, a[w], b[w], op[w]);
      end
      tick();
      ref_alu(a[w], b[w], op[w], er, ez, ee);
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        checks++;
        if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_result, rsp_zero, rsp_err} !== {exp_v, 2'b00, er, ez, ee}) begin
          errors++;
          $display("[TB] FAIL rand_resp[%0d.%0d]: got v=%b%b rdy=%b%b result=%0h z=%b e=%b expected v=%b result=%0h z=%b e=%b",
                   it, s, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_result, rsp_zero, rsp_err,
                   exp_v, er, ez, ee);
        end
        if (s < stall) begin
          if (w == 0) rsp1_ready = 1'($urandom_range(0, 1));
          else rsp0_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      rsp0_ready = (w == 0);
      rsp1_ready = (w == 1);
      tick();
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      favour = 1 - w;
      checks++;
      if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL rand_done[%0d]: got %b expected 000", it, {busy, rsp0_valid, rsp1_valid});
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_illegal();
    test_stall();
    test_reset_mid_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 Port: clk  input  1  sole clock, rising-edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-005 Port: req0_ready / req1_ready  output  1  arbiter accepts requester n's operation this cycle.
REQ-006 Port: req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands.
REQ-007 Port: req0_op / req1_op  input  5  ALU control code: 00000 AND, 00001 OR, 00010 ADD, 00110 SUB.
REQ-008 Port: rsp0_valid / rsp1_valid  output  1  result for requester n is held.
REQ-009 Port: rsp0_ready / rsp1_ready  input  1  requester n consumes the result.
REQ-010 Port: rsp_result  output  WIDTH  captured ALU result, shared by both responders.
REQ-011 Port: rsp_zero  output  1  captured zero flag.
REQ-012 Port: rsp_err  output  1  op was not one of the four legal codes.
REQ-013 Port: alu_a, alu_b  output  WIDTH  operands to the shared ALU.
REQ-014 Port: alu_ctrl  output  5  control code to the shared ALU.
REQ-015 Port: alu_result  input  WIDTH; alu_zero  input  1  combinational ALU outputs.
REQ-016 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, RESP.
REQ-018 IDLE: if any reqN_valid, SHALL grant one winner, assert only the winner's reqN_ready combinationally that cycle, register its a/b/op and a grant id, and go to EXEC.
REQ-019 reqN_ready SHALL be 0 in EXEC and RESP; no request is accepted while busy.
REQ-020 Round-robin: priority pointer SHALL favour requester 0 after reset; on both valid, the pointed requester wins; pointer SHALL move to the non-winner when a response completes.
REQ-021 Single valid requester SHALL win regardless of pointer.
REQ-022 EXEC: alu_a/alu_b/alu_ctrl SHALL drive registered operands; at the clock edge rsp_result/rsp_zero SHALL capture alu_result/alu_zero; go to RESP.
REQ-023 Illegal op: rsp_result SHALL capture 0, rsp_zero 0, rsp_err 1; legal op: rsp_err 0.
REQ-024 Outside EXEC, alu_a, alu_b SHALL be 0 and alu_ctrl 00000.
REQ-025 RESP: only the granted rspN_valid SHALL be 1; rsp_result/zero/err SHALL stay stable until rspN_ready; on rspN_valid&&rspN_ready go to IDLE.
REQ-026 Latency: accept at edge N, rspN_valid high in cycle after edge N+2; back-to-back throughput one op per 3 cycles minimum.
REQ-027 Ready on the non-granted rsp port SHALL be ignored.
REQ-028 Request-side valid dropped after acceptance SHALL not affect the in-flight op.

Reset
REQ-029 reset SHALL asynchronously force IDLE, pointer to requester 0, all ready/valid outputs 0, rsp_result 0, rsp_zero 0, rsp_err 0, busy 0, ALU drive ports 0.
REQ-030 Reset during EXEC or RESP SHALL discard the in-flight op; no response is emitted after release.

Configuration
REQ-031 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win when both valid; pointer unused.
REQ-032 Macro undefined: round-robin per REQ-020.

Verification
REQ-033 Req0 only, a=5,b=3,op=00010 -> req0_ready in accept cycle, rsp0_valid 2 edges later, rsp_result=8, rsp_zero=0, rsp_err=0.
REQ-034 Both valid after reset, req0 SUB 7-7, req1 OR 0xF0|0x0F, held valid -> req0 served first (result 0, zero=1), then req1 (result 0xFF); with ALU_ARB_FIXED_PRIO_EN, req0 served repeatedly.
REQ-035 op=00111 -> rsp_result=0, rsp_zero=0, rsp_err=1, FSM returns IDLE after rsp_ready.
REQ-036 rsp0_ready held low 5 cycles -> rsp0_valid and rsp_result stable all 5 cycles, req1_ready stays 0, busy=1.
REQ-037 reset asserted mid-EXEC -> all outputs 0 immediately, no rsp_valid after release, next req0 accepted in first IDLE cycle.
